blink_mode_ctrl: RTL and testbench
==================================

// Module: blink_mode_ctrl
// PURPOSE
//   Mode controller for the 4-LED blink datapath. Takes the two raw board keys
//   (key_slow, key_fast) and synchronises and debounces them. A press-event FSM
//   selects OFF/SLOW/FAST/ON. A shared prescaler drives the LEDs in the selected
//   mode. Sits between the board pins and led[3:0]; it is the top-level control
//   for the blink example.
// PARAMETERS
//   DEB_CYCLES  500000  stable cycles before a debounced key state changes (>=2)
//   CNT_W       26      prescaler width; slow phase=cnt[CNT_W-1], fast=cnt[CNT_W-2] (>=3)
// PORTS
//   clk        in   1  system clock, all logic on rising edge
//   rst_n      in   1  asynchronous, active-low reset
//   key_slow   in   1  raw pushbutton, active-low (0 = pressed), asynchronous to clk
//   key_fast   in   1  raw pushbutton, active-low (0 = pressed), asynchronous to clk
//   mode       out  2  current mode: 0=OFF 1=SLOW 2=FAST 3=ON
//   mode_chg   out  1  one-cycle pulse on the cycle mode takes a new value
//   led        out  4  LED drive, active-high
// BEHAVIOUR
//   Reset (rst_n=0, async): mode=0, mode_chg=0, led=4'h0, cnt=0.
//     Sync FFs reset to 1 (released). Debounced states reset to released.
//     Debounce counters reset to 0.
//   Sync: 2-FF synchroniser per key; all downstream logic uses the 2nd stage only.
//   Debounce (per key): counter counts while the sync value != debounced state.
//     Counter clears on any cycle where they are equal.
//     When the counter == DEB_CYCLES-1 and the values still differ, the debounced
//     state takes the sync value and the counter clears.
//     Glitches shorter than DEB_CYCLES produce no state change.
//   Press event: registered 1-cycle pulse when the debounced state goes
//     released->pressed. Release generates no event. Holding a key produces one
//     event only.
//   Mode FSM (updates the cycle after the event pulse):
//     slow evt only : SLOW->OFF, else ->SLOW
//     fast evt only : FAST->OFF, else ->FAST
//     both same cyc : ON->OFF,   else ->ON
//     no event      : hold
//   mode_chg=1 on exactly the cycles where mode is written with a different value.
//   Prescaler: cnt free-running +1 per cycle, wraps 2^CNT_W-1 -> 0.
//     cnt is forced to 0 on the cycle mode changes, so every blink mode starts at
//     the dark phase with a full half-period.
//   LED (registered, 1 cycle after mode/cnt):
//     OFF:4'h0  SLOW:{4{cnt[CNT_W-1]}}  FAST:{4{cnt[CNT_W-2]}}  ON:4'hF
//   Latency: raw key edge sampled at edge 0 -> mode updates at edge DEB_CYCLES+4
//     -> led reflects new mode at edge DEB_CYCLES+5.
//   Reset mid-debounce or mid-blink: all state is abandoned. A key held through
//     reset release counts as one new press after DEB_CYCLES.
//   No combinational path from key_* to any output.
// TESTING (DEB_CYCLES=4, CNT_W=4 unless noted)
//   1. Reset held, keys toggling -> mode=0, led=0, mode_chg=0.
//      Release rst_n, keys idle 50 cyc -> no change.
//   2. key_slow low 10 cyc -> mode 0->1 at DEB_CYCLES+4 edges after sampling,
//      mode_chg 1 cyc; led=0 for 8 cyc, then 4'hF for 8 cyc, repeating.
//   3. key_slow 3-cycle low glitch -> no event, mode unchanged.
//      Bounce 1,0,1,0 then stable low -> exactly one event.
//   4. From SLOW, press key_fast -> mode=2, led period 8 cyc (4 off / 4 on).
//      Press key_fast again -> mode=0, led=0.
//   5. Both keys asserted on the same cycle, from OFF -> mode=3, led=4'hF.
//      Repeat -> mode=0. Skew of 1 cycle gives FAST or SLOW then another mode,
//      per FSM table.
//   6. Assert rst_n=0 mid-debounce and in FAST -> outputs 0 immediately (async).
//      Key held across release -> single event to SLOW/FAST after DEB_CYCLES+4.

Source files
------------

// File: rtl/blink_mode_ctrl.sv
// Blink-example mode controller: synchronises and debounces two raw keys,
// selects OFF/SLOW/FAST/ON from press events and drives the four LEDs.
module blink_mode_ctrl #(
  parameter int unsigned DEB_CYCLES = 500000,
  parameter int unsigned CNT_W      = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_slow,
  input  logic       key_fast,
  output logic [1:0] mode,
  output logic       mode_chg,
  output logic [3:0] led
);

  localparam int unsigned NKEY  = 2;
  localparam int unsigned DEB_W = $clog2(DEB_CYCLES);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_SLOW = 2'd1,
    MODE_FAST = 2'd2,
    MODE_ON   = 2'd3
  } mode_e;

  // Bit 0 is the slow key, bit 1 the fast key; all key levels are active-low.
  logic [NKEY-1:0] key_raw;
  logic [NKEY-1:0] sync1;
  logic [NKEY-1:0] sync2;
  logic [NKEY-1:0] deb;
  logic [NKEY-1:0] deb_d;
  logic [NKEY-1:0] deb_dd;
  logic [NKEY-1:0] evt;

  mode_e            state;
  mode_e            state_nx;
  logic             chg_nx;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       led_nx;

  assign key_raw = {key_fast, key_slow};
  assign mode    = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
    end
  end

  // Per-key debounce: the state follows the synchronised level only after
  // DEB_CYCLES consecutive cycles of disagreement.
  for (genvar g = 0; g < NKEY; g++) begin : g_key
    logic [DEB_W-1:0] deb_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        deb[g]  <= 1'b1;
        deb_cnt <= '0;
      end else if (sync2[g] == deb[g]) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb[g]  <= sync2[g];
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end
  end

  // Press detection runs on a retimed copy of the debounced level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_d  <= '1;
      deb_dd <= '1;
      evt    <= '0;
    end else begin
      deb_d  <= deb;
      deb_dd <= deb_d;
      evt    <= deb_dd & ~deb_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= MODE_OFF;
      mode_chg <= 1'b0;
    end else begin
      state    <= state_nx;
      mode_chg <= chg_nx;
    end
  end

  always_comb begin
    state_nx = state;
    chg_nx   = 1'b0;
    case (evt)
      2'b01:   state_nx = (state == MODE_SLOW) ? MODE_OFF : MODE_SLOW;
      2'b10:   state_nx = (state == MODE_FAST) ? MODE_OFF : MODE_FAST;
      2'b11:   state_nx = (state == MODE_ON)   ? MODE_OFF : MODE_ON;
      default: state_nx = state;
    endcase
    chg_nx = (state_nx != state);
  end

  // Restarting the prescaler on a mode change gives every blink mode a full dark half-period first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (chg_nx) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    led_nx = 4'h0;
    case (state)
      MODE_SLOW: led_nx = {4{cnt[CNT_W-1]}};
      MODE_FAST: led_nx = {4{cnt[CNT_W-2]}};
      MODE_ON:   led_nx = 4'hF;
      default:   led_nx = 4'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= 4'h0;
    end else begin
      led <= led_nx;
    end
  end

endmodule

// File: tb/tb_blink_mode_ctrl.sv
// Scoreboard bench for blink_mode_ctrl: mode-change and LED expectations are
// queued when keys are driven and compared as the DUT produces them.
module tb_blink_mode_ctrl;

  localparam int unsigned DEB  = 4;
  localparam int unsigned CNTW = 4;
  // Key driven after edge c is sampled at c+1; mode updates DEB+4 edges later.
  localparam int LAT = DEB + 5;

  typedef struct { int cyc; logic [1:0] mode; } mode_exp_t;
  typedef struct { int cyc; logic [3:0] led;  } led_exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_slow;
  logic       key_fast;
  logic [1:0] mode;
  logic       mode_chg;
  logic [3:0] led;

  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;
  bit         mon_en = 1'b0;
  logic [1:0] model_mode;
  mode_exp_t  mode_q[$];
  led_exp_t   led_q[$];

  blink_mode_ctrl #(.DEB_CYCLES(DEB), .CNT_W(CNTW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_slow (key_slow),
    .key_fast (key_fast),
    .mode     (mode),
    .mode_chg (mode_chg),
    .led      (led)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [1:0] next_mode(input logic [1:0] cur, input bit s, input bit f);
    if (s && f) return (cur == 2'd3) ? 2'd0 : 2'd3;
    if (s)      return (cur == 2'd1) ? 2'd0 : 2'd1;
    if (f)      return (cur == 2'd2) ? 2'd0 : 2'd2;
    return cur;
  endfunction

  // LED value j cycles into a mode (counter value j, dark phase first).
  function automatic logic [3:0] exp_led(input logic [1:0] m, input int j);
    case (m)
      2'd1:    return (j < 8) ? 4'h0 : 4'hF;
      2'd2:    return ((j % 8) < 4) ? 4'h0 : 4'hF;
      2'd3:    return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

  task automatic expect_event(input int at, input bit s, input bit f, input bit chk_led);
    logic [1:0] nm;
    nm = next_mode(model_mode, s, f);
    if (nm != model_mode) begin
      mode_q.push_back('{at, nm});
      if (chk_led)
        for (int j = 0; j < 16; j++) led_q.push_back('{at + 1 + j, exp_led(nm, j)});
      model_mode = nm;
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic settle();
    int n;
    n = 0;
    while ((mode_q.size() != 0 || led_q.size() != 0) && n < 60) begin
      hold(1);
      n++;
    end
    check("mode_q_drained", mode_q.size(), 0);
    check("led_q_drained", led_q.size(), 0);
    mode_q.delete();
    led_q.delete();
    check("mode_idle", mode, model_mode);
  endtask

  task automatic press(input bit s, input bit f);
    if (s) key_slow = 1'b0;
    if (f) key_fast = 1'b0;
    expect_event(cyc + LAT, s, f, 1'b1);
    hold(10);
    key_slow = 1'b1;
    key_fast = 1'b1;
    hold(30);
    settle();
  endtask

  task automatic press_skew(input bit slow_first);
    if (slow_first) key_slow = 1'b0;
    else            key_fast = 1'b0;
    expect_event(cyc + LAT, slow_first, !slow_first, 1'b0);
    hold(1);
    if (slow_first) key_fast = 1'b0;
    else            key_slow = 1'b0;
    expect_event(cyc + LAT, !slow_first, slow_first, 1'b1);
    hold(10);
    key_slow = 1'b1;
    key_fast = 1'b1;
    hold(30);
    settle();
  endtask

  // Monitor: pops expectations as mode changes and LED samples arrive.
  always @(negedge clk) begin : mon
    mode_exp_t me;
    led_exp_t  le;
    if (mon_en) begin
      if (mode_chg) begin
        if (mode_q.size() == 0) begin
          check("spurious_chg", 32'(mode_chg), 32'd0);
        end else begin
          me = mode_q.pop_front();
          check("chg_cycle", cyc, me.cyc);
          check("mode_val", mode, me.mode);
        end
      end
      if (led_q.size() != 0 && led_q[0].cyc == cyc) begin
        le = led_q.pop_front();
        check("led", led, le.led);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int m;
    rst_n      = 1'b0;
    key_slow   = 1'b1;
    key_fast   = 1'b1;
    model_mode = 2'd0;

    // Reset held with keys toggling, then idle keys after release.
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      key_slow = 1'(i % 2);
      key_fast = 1'((i / 3) % 2);
      if (i % 4 == 3) begin
        check("rst_mode", mode, 2'd0);
        check("rst_led", led, 4'h0);
        check("rst_chg", mode_chg, 1'b0);
      end
    end
    key_slow = 1'b1;
    key_fast = 1'b1;
    rst_n    = 1'b1;
    mon_en   = 1'b1;
    hold(50);
    check("idle_mode", mode, 2'd0);
    check("idle_led", led, 4'h0);

    // OFF -> SLOW with full blink pattern.
    press(1'b1, 1'b0);

    // Short glitch: no event.
    key_slow = 1'b0;
    hold(3);
    key_slow = 1'b1;
    hold(20);
    settle();

    // Bouncing press then stable low: one event, SLOW -> OFF.
    key_slow = 1'b0;
    hold(1);
    key_slow = 1'b1;
    hold(1);
    key_slow = 1'b0;
    expect_event(cyc + LAT, 1'b1, 1'b0, 1'b1);
    hold(10);
    key_slow = 1'b1;
    hold(30);
    settle();

    // OFF -> SLOW -> FAST -> OFF.
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);

    // Both keys together: OFF -> ON -> OFF.
    press(1'b1, 1'b1);
    press(1'b1, 1'b1);

    // One-cycle skew: OFF -> SLOW -> FAST, then FAST -> OFF -> SLOW.
    press_skew(1'b1);
    press_skew(1'b0);

    // SLOW -> FAST, then async reset mid-blink and mid-debounce.
    m = cyc + LAT;
    key_fast = 1'b0;
    expect_event(m, 1'b0, 1'b1, 1'b0);
    hold(10);
    key_fast = 1'b1;
    hold(5);
    key_slow = 1'b0;
    hold(1);
    check("pre_rst_mode", mode, 2'd2);
    check("pre_rst_led", led, 4'hF);
    #2;
    rst_n  = 1'b0;
    mon_en = 1'b0;
    #1;
    check("async_rst_mode", mode, 2'd0);
    check("async_rst_led", led, 4'h0);
    check("async_rst_chg", mode_chg, 1'b0);
    mode_q.delete();
    led_q.delete();
    model_mode = 2'd0;
    hold(3);

    // Slow key held through reset release: exactly one event.
    rst_n  = 1'b1;
    mon_en = 1'b1;
    expect_event(cyc + LAT, 1'b1, 1'b0, 1'b1);
    hold(12);
    key_slow = 1'b1;
    hold(30);
    settle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
